tree_loader: RTL and testbench

- Upstream configuration sequencer for treeval.
- Accepts a framed word stream (header plus per-node records) over a valid/ready handshake.
- Emits the conf_nodes pulse and the mem_par / mem_rew / mem_act / mem_weight write strobes in the exact format treeval consumes.
- Checks frame legality (node count, topological parent order) and reports completion and errors to the host.

---
 rtl/treeval_pkg.sv | 22 ++
 rtl/tree_loader.sv | 147 ++++++++++++++
 tb/tb_tree_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/treeval_pkg.sv
// Shared widths, enums and constants for treeval and its configuration loader.
package treeval_pkg;
  localparam int W_ADDR   = 10;
  localparam int W_N_DATA = 12;
  localparam int W_C_DATA = 10;
  localparam int W_REWARD = W_N_DATA;
  localparam int W_ACTION = 3;

  localparam logic [W_ACTION-1:0] ACT_PLAY    = 3'b001;
  localparam logic [W_ACTION-1:0] ACT_NO_PLAY = 3'b000;

  typedef enum logic [1:0] {FLD_PAR, FLD_REW, FLD_ACT, FLD_WGT} field_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_ZERO  = 2'b01,
    ERR_OVF   = 2'b10,
    ERR_ORDER = 2'b11
  } err_e;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_NODE, S_DRAIN, S_FIN} state_e;
endpackage

// File: rtl/tree_loader.sv
// Turns a framed header+record word stream into treeval conf/mem write strobes,
// validating node count and parent ordering along the way.
module tree_loader
  import treeval_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [W_N_DATA-1:0] in_data_i,
  output logic                conf_nodes_o,
  output logic [W_C_DATA-1:0] conf_data_o,
  output logic                mem_par_o,
  output logic                mem_rew_o,
  output logic                mem_act_o,
  output logic                mem_weight_o,
  output logic [W_ADDR-1:0]   mem_addr_o,
  output logic [W_N_DATA-1:0] mem_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o
);

  state_e                state_q, state_d;
  err_e                  err_code_q, err_code_d;
  field_e                field_q;
  logic [W_ADDR-1:0]     node_q;
  logic [W_C_DATA-1:0]   count_q;
  logic [3:0]            stb_q;
  logic                  conf_nodes_q;
  logic [W_C_DATA-1:0]   conf_data_q;
  logic [W_ADDR-1:0]     mem_addr_q;
  logic [W_N_DATA-1:0]   mem_data_q;
  logic                  err_q;

  logic                  xfer, hdr_zero, hdr_ovf, par_bad, last_word;
  logic [W_C_DATA:0]     node_nx;

  assign xfer      = in_valid_i & in_ready_o;
  assign hdr_zero  = (in_data_i == '0);
  assign hdr_ovf   = |in_data_i[W_N_DATA-1:W_C_DATA];
  assign par_bad   = (field_q == FLD_PAR) && (in_data_i >= W_N_DATA'(node_q));
  // Last word of the frame is node N-1's weight; widen to avoid wrap at max count.
  assign node_nx   = (W_C_DATA+1)'(node_q) + (W_C_DATA+1)'(1);
  assign last_word = (field_q == FLD_WGT) && (node_nx == {1'b0, count_q});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          state_d    = S_HDR;
          err_code_d = ERR_NONE;
        end
        S_HDR: if (xfer) begin
          if (hdr_zero) begin
            state_d    = S_FIN;
            err_code_d = ERR_ZERO;
          end else if (hdr_ovf) begin
            state_d    = S_FIN;
            err_code_d = ERR_OVF;
          end else if (in_data_i == W_N_DATA'(1)) state_d = S_FIN;
          else                                     state_d = S_NODE;
        end
        S_NODE: if (xfer) begin
          if (par_bad) begin
            state_d    = S_DRAIN;
            err_code_d = ERR_ORDER;
          end else if (last_word) state_d = S_FIN;
        end
        S_DRAIN: if (xfer && last_word) state_d = S_FIN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o = (state_q == S_HDR) || (state_q == S_NODE) || (state_q == S_DRAIN);
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_FIN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_code_q   <= ERR_NONE;
      err_q        <= 1'b0;
      field_q      <= FLD_PAR;
      node_q       <= '0;
      count_q      <= '0;
      stb_q        <= '0;
      conf_nodes_q <= 1'b0;
      conf_data_q  <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      stb_q        <= '0;
      conf_nodes_q <= 1'b0;
      err_code_q   <= err_code_d;
      // err only publishes on entry to FIN and is wiped when a new frame starts
      if (state_d == S_FIN && state_q != S_FIN)           err_q <= (err_code_d != ERR_NONE);
      else if (state_q == S_IDLE && start_i && !abort_i)  err_q <= 1'b0;
      if (!abort_i && xfer) begin
        case (state_q)
          S_HDR: if (!hdr_zero && !hdr_ovf) begin
            conf_nodes_q <= 1'b1;
            conf_data_q  <= in_data_i[W_C_DATA-1:0];
            count_q      <= in_data_i[W_C_DATA-1:0];
            node_q       <= W_ADDR'(1);
            field_q      <= FLD_PAR;
          end
          S_NODE, S_DRAIN: begin
            if (state_q == S_NODE && !par_bad) begin
              stb_q[field_q] <= 1'b1;
              mem_addr_q     <= node_q;
              mem_data_q     <= (field_q == FLD_ACT) ? W_N_DATA'(in_data_i[W_ACTION-1:0])
                                                     : in_data_i;
            end
            field_q <= field_e'(field_q + 2'd1);
            if (field_q == FLD_WGT) node_q <= node_q + W_ADDR'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign {mem_weight_o, mem_act_o, mem_rew_o, mem_par_o} = stb_q;
  assign conf_nodes_o = conf_nodes_q;
  assign conf_data_o  = conf_data_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_tree_loader.sv
// Randomized + directed bench for tree_loader against a frame-level reference model.
module tb_tree_loader;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0, abort_i = 1'b0, in_valid_i = 1'b0;
  logic [11:0] in_data_i = '0;
  logic        in_ready_o, conf_nodes_o, mem_par_o, mem_rew_o, mem_act_o, mem_weight_o;
  logic        busy_o, done_o, err_o;
  logic [9:0]  conf_data_o, mem_addr_o;
  logic [11:0] mem_data_o;
  logic [1:0]  err_code_o;

  int errors = 0, checks = 0;
  logic [11:0] fw[$];

  tree_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .conf_nodes_o(conf_nodes_o), .conf_data_o(conf_data_o),
    .mem_par_o(mem_par_o), .mem_rew_o(mem_rew_o), .mem_act_o(mem_act_o),
    .mem_weight_o(mem_weight_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] stb();
    return {mem_weight_o, mem_act_o, mem_rew_o, mem_par_o};
  endfunction

  // Frame-level model: word k>=1 belongs to node (k-1)/4+1, field (k-1)%4.
  task automatic model(output int len, output int bad_k, output logic [1:0] code);
    int n;
    n     = int'(fw[0]);
    bad_k = 1 << 30;
    code  = 2'b00;
    if (n == 0)            begin len = 1; code = 2'b01; end
    else if (n >= 1024)    begin len = 1; code = 2'b10; end
    else begin
      len = 1 + 4 * (n - 1);
      for (int k = 1; k < len; k++)
        if ((k - 1) % 4 == 0 && int'(fw[k]) >= (k - 1) / 4 + 1 && bad_k > k) begin
          bad_k = k;
          code  = 2'b11;
        end
    end
  endtask

  task automatic run_frame(input int gap_mode, input string nm);
    int len, bad_k, k, prev_k, nd, fl;
    logic [1:0]  code;
    logic [3:0]  e_stb;
    logic [11:0] e_data;
    bit prev_x, v, done_seen, tog;
    model(len, bad_k, code);
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    k = 0; prev_x = 0; prev_k = 0; done_seen = 0; tog = 1;
    for (int cyc = 0; cyc < 2000 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge clk_i);
      e_stb = '0; e_data = '0; nd = 0; fl = 0;
      if (prev_x && prev_k > 0 && prev_k < bad_k) begin
        nd = (prev_k - 1) / 4 + 1;
        fl = (prev_k - 1) % 4;
        e_stb[fl] = 1'b1;
        e_data = (fl == 2) ? (fw[prev_k] & 12'h007) : fw[prev_k];
      end
      chk({nm, ":conf"}, conf_nodes_o, prev_x && prev_k == 0 && code != 2'b01 && code != 2'b10);
      if (prev_x && prev_k == 0 && code != 2'b01 && code != 2'b10)
        chk({nm, ":conf_data"}, conf_data_o, fw[0] & 12'h3FF);
      chk({nm, ":stb"}, stb(), e_stb);
      if (e_stb != 0) begin
        chk({nm, ":addr"}, mem_addr_o, nd);
        chk({nm, ":data"}, mem_data_o, e_data);
      end
      chk({nm, ":busy"}, busy_o, 1);
      if (prev_x && prev_k == len - 1) begin
        done_seen = 1;
        chk({nm, ":done"}, done_o, 1);
        chk({nm, ":ready_fin"}, in_ready_o, 0);
        chk({nm, ":err"}, err_o, code != 2'b00);
        chk({nm, ":err_code"}, err_code_o, code);
        in_valid_i = 1'b0;
      end else begin
        chk({nm, ":done_early"}, done_o, 0);
        chk({nm, ":ready"}, in_ready_o, 1);
        case (gap_mode)
          0:       v = 1;
          1:       v = tog;
          default: v = ($urandom_range(0, 3) != 0);
        endcase
        tog = ~tog;
        v = v && (k < len);
        in_valid_i = v;
        in_data_i  = (k < len) ? fw[k] : 12'($urandom);
        prev_x = v; prev_k = k;
        if (v) k++;
      end
    end
    if (!done_seen) chk({nm, ":done_timeout"}, 0, 1);
    @(negedge clk_i);
    chk({nm, ":idle_busy"}, busy_o, 0);
    chk({nm, ":idle_done"}, done_o, 0);
    chk({nm, ":idle_err"}, err_o, code != 2'b00);
  endtask

  task automatic push_node(input int par, input int rew, input int act, input int wgt);
    fw.push_back(12'(par)); fw.push_back(12'(rew)); fw.push_back(12'(act)); fw.push_back(12'(wgt));
  endtask

  task automatic drive_words(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i); in_valid_i = 1'b1; in_data_i = fw[i];
    end
  endtask

  initial begin
    int n, node;
    int pars[6] = '{0, 0, 0, 1, 1, 1};
    int rews[6] = '{0, -10, 0, 100, -50, 10};
    int acts[6] = '{1, 1, 0, 1, 1, 0};

    #1;
    chk("rst_busy", busy_o, 0);   chk("rst_ready", in_ready_o, 0);
    chk("rst_stb", stb(), 0);     chk("rst_conf", conf_nodes_o, 0);
    chk("rst_addr", mem_addr_o, 0); chk("rst_err", err_o, 0);
    chk("rst_code", err_code_o, 0); chk("rst_done", done_o, 0);
    @(negedge clk_i); rst_ni = 1'b1;

    fw = {12'd7};
    for (int i = 0; i < 6; i++) push_node(pars[i], rews[i], acts[i], i + 1);
    run_frame(0, "tree7");

    fw = {12'd0};   run_frame(0, "hdr0");
    fw = {12'hC07}; run_frame(0, "hdr_ovf");

    fw = {12'd3}; push_node(0, 5, 7, 9); push_node(2, 1, 1, 1);
    run_frame(0, "bad_par");

    fw = {12'd1}; run_frame(0, "hdr1");

    fw = {12'd4}; push_node(0, 11, 12'hFFF, 3); push_node(1, 22, 2, 4); push_node(2, 33, 5, 6);
    run_frame(1, "toggle");

    // start+abort together in IDLE must not begin a frame
    @(negedge clk_i); start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; abort_i = 1'b0;
    chk("start_abort_busy", busy_o, 0);

    // abort after 5 node words, racing a 6th transfer
    fw = {12'd4}; push_node(0, 1, 1, 1); push_node(1, 2, 2, 2);
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0; in_valid_i = 1'b1; in_data_i = fw[0];
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_i); in_data_i = fw[i];
    end
    @(negedge clk_i);
    chk("abort_last_par", stb(), 4'b0001);
    chk("abort_last_addr", mem_addr_o, 2);
    abort_i = 1'b1; in_data_i = fw[6];
    @(negedge clk_i); abort_i = 1'b0; in_valid_i = 1'b0;
    chk("abort_busy", busy_o, 0);  chk("abort_stb", stb(), 0);
    chk("abort_done", done_o, 0);  chk("abort_ready", in_ready_o, 0);
    chk("abort_err", err_o, 0);
    @(negedge clk_i);
    chk("abort_no_done", done_o, 0);

    // reset while draining an erroneous frame
    fw = {12'd3}; push_node(0, 7, 3, 8); push_node(2, 0, 0, 0);
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    drive_words(7);
    @(negedge clk_i); in_valid_i = 1'b0;
    chk("pre_rst_code", err_code_o, 3);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);  chk("mid_rst_ready", in_ready_o, 0);
    chk("mid_rst_code", err_code_o, 0); chk("mid_rst_addr", mem_addr_o, 0);
    chk("mid_rst_data", mem_data_o, 0); chk("mid_rst_conf_data", conf_data_o, 0);
    chk("mid_rst_stb", stb(), 0);
    @(negedge clk_i); rst_ni = 1'b1;
    fw = {12'd3}; push_node(0, 4, 1, 2); push_node(1, 6, 0, 3);
    run_frame(0, "post_rst");

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 9))
        0:       fw = {12'd0};
        1:       fw = {12'(($urandom_range(1, 3) << 10) | $urandom_range(0, 1023))};
        default: begin
          n  = $urandom_range(1, 8);
          fw = {12'(n)};
          for (int k = 1; k < 1 + 4 * (n - 1); k++) begin
            node = (k - 1) / 4 + 1;
            if ((k - 1) % 4 == 0)
              fw.push_back(12'(($urandom_range(0, 9) == 0) ? $urandom_range(node, node + 3)
                                                           : $urandom_range(0, node - 1)));
            else
              fw.push_back(12'($urandom_range(0, 4095)));
          end
        end
      endcase
      run_frame($urandom_range(0, 2), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
